// File: rtl/cram_arb_pkg.sv
// Shared types and default sizing for the CRAM two-port arbiter.
package cram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef logic port_t;

  localparam port_t PORT0 = 1'b0;
  localparam port_t PORT1 = 1'b1;

  localparam int ADDR_W_DEF  = 22;
  localparam int DATA_W_DEF  = 16;
  localparam int MAX_RUN_DEF = 4;
  localparam int TIMEOUT_DEF = 255;

endpackage

// File: rtl/cram_arbiter.sv
// Shares the CRAM word port between the sample-fetch path (port 0, priority)
// and the loader/bridge path (port 1), one transaction at a time with a watchdog.
module cram_arbiter
  import cram_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MAX_RUN = MAX_RUN_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_wr,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_err,
  input  logic              p1_req,
  input  logic              p1_wr,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_err,
  output logic              m_req,
  output logic              m_wr,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_done,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam int RUN_W  = $clog2(MAX_RUN + 1);
  localparam int WCNT_W = $clog2(TIMEOUT + 1);
  localparam logic [RUN_W-1:0]  RUN_MAX = RUN_W'(MAX_RUN);
  localparam logic [WCNT_W-1:0] WCNT_TO = WCNT_W'(TIMEOUT);

  state_t              state_q, state_d;
  port_t               win_q, win_d;
  logic [RUN_W-1:0]    run_q, run_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic                m_req_q, m_req_d;
  logic                m_wr_q, m_wr_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                ack_q, ack_d;
  logic                grant1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      win_q     <= PORT0;
      run_q     <= '0;
      wcnt_q    <= '0;
      m_req_q   <= 1'b0;
      m_wr_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      run_q     <= run_d;
      wcnt_q    <= wcnt_d;
      m_req_q   <= m_req_d;
      m_wr_q    <= m_wr_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      ack_q     <= ack_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    run_d     = run_q;
    wcnt_d    = wcnt_q;
    m_req_d   = 1'b0;
    m_wr_d    = m_wr_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    ack_d     = 1'b0;
    grant1    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Port 1 only wins a contested grant once port 0 has used its run.
        grant1 = p1_req && (!p0_req || (run_q == RUN_MAX));
        if (p0_req || p1_req) begin
          win_d     = grant1 ? PORT1 : PORT0;
          run_d     = grant1 ? '0 : ((run_q == RUN_MAX) ? run_q : run_q + 1'b1);
          m_wr_d    = grant1 ? p1_wr    : p0_wr;
          m_addr_d  = grant1 ? p1_addr  : p0_addr;
          m_wdata_d = grant1 ? p1_wdata : p0_wdata;
          m_req_d   = 1'b1;
          wcnt_d    = '0;
          state_d   = WAIT;
        end else begin
          run_d = '0;
        end
      end
      WAIT: begin
        // A completion on the timeout cycle itself still counts as success.
        if (m_done) begin
          rdata_d = m_wr_q ? '0 : m_rdata;
          err_d   = 1'b0;
          ack_d   = 1'b1;
          state_d = RESP;
        end else if (wcnt_q == WCNT_TO) begin
          rdata_d = '0;
          err_d   = 1'b1;
          ack_d   = 1'b1;
          state_d = RESP;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      RESP: begin
        rdata_d = '0;
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign m_req    = m_req_q;
  assign m_wr     = m_wr_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;

  assign p0_ack   = ack_q && (win_q == PORT0);
  assign p1_ack   = ack_q && (win_q == PORT1);
  assign p0_rdata = p0_ack ? rdata_q : '0;
  assign p1_rdata = p1_ack ? rdata_q : '0;
  assign p0_err   = p0_ack && err_q;
  assign p1_err   = p1_ack && err_q;

endmodule

// File: tb/tb_cram_arbiter.sv
// Self-checking bench for cram_arbiter: directed scenarios plus a randomized
// two-requester run checked against a transaction-level reference model.
module tb_cram_arbiter;

  localparam int ADDR_W  = 22;
  localparam int DATA_W  = 16;
  localparam int MAX_RUN = 4;
  localparam int TIMEOUT = 255;

  logic              clk;
  logic              reset;
  logic              p0_req, p0_wr, p1_req, p1_wr;
  logic [ADDR_W-1:0] p0_addr, p1_addr;
  logic [DATA_W-1:0] p0_wdata, p1_wdata;
  logic              p0_ack, p0_err, p1_ack, p1_err;
  logic [DATA_W-1:0] p0_rdata, p1_rdata;
  logic              m_req, m_wr, m_done;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata, m_rdata;
  logic [75:0]       all_out;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  cram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_RUN(MAX_RUN), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_wr(p0_wr), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_wr(p1_wr), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_done(m_done), .m_rdata(m_rdata)
  );

  assign all_out = {p0_ack, p0_err, p0_rdata, p1_ack, p1_err, p1_rdata,
                    m_req, m_wr, m_addr, m_wdata};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if (all_out !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", all_out);
    end
    reset = 1'b0;
    step();
    checks++;
    if (all_out !== '0) begin
      failures++;
      $display("FAIL post_reset_idle got=%h exp=0", all_out);
    end
    $display("test_reset done");
  endtask

  task automatic test_p0_read();
    p0_req = 1'b1; p0_wr = 1'b0; p0_addr = 22'h000123; p0_wdata = '0;
    step();
    checks++;
    if (m_req !== 1'b1 || m_addr !== 22'h000123 || m_wr !== 1'b0) begin
      failures++;
      $display("FAIL p0_read_cmd got req=%b addr=%h wr=%b exp req=1 addr=000123 wr=0", m_req, m_addr, m_wr);
    end
    step();
    checks++;
    if (m_req !== 1'b0 || p0_ack !== 1'b0) begin
      failures++;
      $display("FAIL p0_read_strobe got req=%b ack=%b exp req=0 ack=0", m_req, p0_ack);
    end
    step();
    m_done = 1'b1; m_rdata = 16'hBEEF;
    checks++;
    if (p0_ack !== 1'b0) begin
      failures++;
      $display("FAIL p0_read_early_ack got=%b exp=0", p0_ack);
    end
    step();
    m_done = 1'b0; m_rdata = '0;
    checks++;
    if (p0_ack !== 1'b1 || p0_rdata !== 16'hBEEF || p0_err !== 1'b0 || p1_ack !== 1'b0 || p1_rdata !== '0) begin
      failures++;
      $display("FAIL p0_read_ack got ack=%b rdata=%h err=%b p1_ack=%b exp ack=1 rdata=beef err=0 p1_ack=0", p0_ack, p0_rdata, p0_err, p1_ack);
    end
    p0_req = 1'b0;
    step();
    checks++;
    if (p0_ack !== 1'b0 || p0_rdata !== '0) begin
      failures++;
      $display("FAIL p0_read_ack_width got ack=%b rdata=%h exp ack=0 rdata=0", p0_ack, p0_rdata);
    end
    step();
    $display("test_p0_read done");
  endtask

  task automatic test_p1_write();
    int n;
    p1_req = 1'b1; p1_wr = 1'b1; p1_addr = 22'h3FFFFF; p1_wdata = 16'h5A5A;
    n = 0;
    do begin step(); n++; end while (m_req !== 1'b1 && n < 5);
    checks++;
    if (m_req !== 1'b1 || m_wr !== 1'b1 || m_addr !== 22'h3FFFFF || m_wdata !== 16'h5A5A) begin
      failures++;
      $display("FAIL p1_write_cmd got req=%b wr=%b addr=%h wdata=%h exp 1 1 3fffff 5a5a", m_req, m_wr, m_addr, m_wdata);
    end
    step();
    m_done = 1'b1; m_rdata = 16'h1234;
    step();
    m_done = 1'b0;
    checks++;
    if (p1_ack !== 1'b1 || p1_rdata !== '0 || p1_err !== 1'b0 || p0_ack !== 1'b0) begin
      failures++;
      $display("FAIL p1_write_ack got ack=%b rdata=%h err=%b p0_ack=%b exp 1 0 0 0", p1_ack, p1_rdata, p1_err, p0_ack);
    end
    p1_req = 1'b0;
    step();
    step();
    $display("test_p1_write done");
  endtask

  task automatic test_fairness();
    int exp_seq[10];
    int n;
    int got;
    logic [DATA_W-1:0] d;
    exp_seq = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    p0_req = 1'b1; p0_wr = 1'b0; p0_addr = 22'h000AAA;
    p1_req = 1'b1; p1_wr = 1'b0; p1_addr = 22'h000BBB;
    for (int g = 0; g < 10; g++) begin
      n = 0;
      while (m_req !== 1'b1 && n < 10) begin step(); n++; end
      got = (m_addr == 22'h000BBB) ? 1 : 0;
      checks++;
      if (m_req !== 1'b1 || got != exp_seq[g]) begin
        failures++;
        $display("FAIL fairness_grant[%0d] got req=%b port=%0d exp req=1 port=%0d", g, m_req, got, exp_seq[g]);
      end
      step();
      d = 16'(16'h0100 + g);
      m_done = 1'b1; m_rdata = d;
      step();
      m_done = 1'b0;
      checks++;
      if (exp_seq[g] == 1 ? (p1_ack !== 1'b1 || p0_ack !== 1'b0 || p1_rdata !== d)
                          : (p0_ack !== 1'b1 || p1_ack !== 1'b0 || p0_rdata !== d)) begin
        failures++;
        $display("FAIL fairness_ack[%0d] got p0_ack=%b p1_ack=%b p0_rdata=%h p1_rdata=%h exp port=%0d rdata=%h", g, p0_ack, p1_ack, p0_rdata, p1_rdata, exp_seq[g], d);
      end
      step();
    end
    p0_req = 1'b0; p1_req = 1'b0;
    step();
    step();
    $display("test_fairness done");
  endtask

  task automatic test_timeout();
    int t;
    bit early;
    bit late;
    t = cyc;
    p0_req = 1'b1; p0_wr = 1'b0; p0_addr = 22'h0000F0;
    early = 1'b0;
    while (cyc < t + TIMEOUT + 2) begin
      step();
      if (cyc < t + TIMEOUT + 2 && (p0_ack || p1_ack)) early = 1'b1;
    end
    checks++;
    if (early) begin
      failures++;
      $display("FAIL timeout_early_ack got=1 exp=0");
    end
    checks++;
    if (p0_ack !== 1'b1 || p0_err !== 1'b1 || p0_rdata !== '0) begin
      failures++;
      $display("FAIL timeout_ack got ack=%b err=%b rdata=%h exp ack=1 err=1 rdata=0", p0_ack, p0_err, p0_rdata);
    end
    p0_req = 1'b0;
    repeat (10) step();
    m_done = 1'b1; m_rdata = 16'hDEAD;
    step();
    m_done = 1'b0;
    late = 1'b0;
    repeat (4) begin
      step();
      if (p0_ack || p1_ack || m_req) late = 1'b1;
    end
    checks++;
    if (late) begin
      failures++;
      $display("FAIL timeout_late_done got activity=1 exp=0");
    end
    $display("test_timeout done");
  endtask

  task automatic test_timeout_edge();
    int t;
    bit early;
    t = cyc;
    p0_req = 1'b1; p0_wr = 1'b0; p0_addr = 22'h0000F1;
    early = 1'b0;
    while (cyc < t + 1 + TIMEOUT) begin
      step();
      if (p0_ack || p1_ack) early = 1'b1;
    end
    m_done = 1'b1; m_rdata = 16'hC0DE;
    step();
    m_done = 1'b0;
    checks++;
    if (early || p0_ack !== 1'b1 || p0_err !== 1'b0 || p0_rdata !== 16'hC0DE) begin
      failures++;
      $display("FAIL timeout_edge got early=%b ack=%b err=%b rdata=%h exp early=0 ack=1 err=0 rdata=c0de", early, p0_ack, p0_err, p0_rdata);
    end
    p0_req = 1'b0;
    step();
    step();
    $display("test_timeout_edge done");
  endtask

  task automatic test_reset_in_wait();
    bit quiet;
    p0_req = 1'b1; p0_wr = 1'b0; p0_addr = 22'h000055;
    step();
    step();
    reset = 1'b1; p0_req = 1'b0;
    step();
    checks++;
    if (all_out !== '0) begin
      failures++;
      $display("FAIL reset_in_wait got=%h exp=0", all_out);
    end
    reset = 1'b0;
    step();
    m_done = 1'b1; m_rdata = 16'h1111;
    step();
    m_done = 1'b0;
    quiet = 1'b1;
    repeat (4) begin
      step();
      if (p0_ack || p1_ack || m_req) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin
      failures++;
      $display("FAIL reset_stale_done got activity=1 exp=0");
    end
    p0_req = 1'b1; p0_addr = 22'h000066;
    step();
    checks++;
    if (m_req !== 1'b1 || m_addr !== 22'h000066) begin
      failures++;
      $display("FAIL reset_recover_cmd got req=%b addr=%h exp req=1 addr=000066", m_req, m_addr);
    end
    step();
    m_done = 1'b1; m_rdata = 16'h7777;
    step();
    m_done = 1'b0;
    checks++;
    if (p0_ack !== 1'b1 || p0_rdata !== 16'h7777 || p0_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_recover_ack got ack=%b rdata=%h err=%b exp 1 7777 0", p0_ack, p0_rdata, p0_err);
    end
    p0_req = 1'b0;
    step();
    step();
    $display("test_reset_in_wait done");
  endtask

  // Reference model: transactions are serialized; the arbiter samples requests
  // only on the cycle after an ack (or any idle cycle), port 0 wins unless it
  // already holds MAX_RUN consecutive contested-or-not grants and port 1 waits.
  task automatic test_random(input int ncyc);
    logic              pend[2];
    logic              cw[2];
    logic [ADDR_W-1:0] ca[2];
    logic [DATA_W-1:0] cd[2];
    int idle_at, mreq_at, done_at, ack_at, streak, win, ntx;
    logic              exp_wr;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_wdata, exp_rdata, resp_data;
    logic              e0, e1;
    bit                in_wait;
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int p = 0; p < 2; p++) begin cw[p] = 1'b0; ca[p] = '0; cd[p] = '0; end
    p0_req = 1'b0; p1_req = 1'b0; m_done = 1'b0;
    step();
    idle_at = cyc; mreq_at = -1; done_at = -1; ack_at = -1;
    streak = 0; win = 0; ntx = 0;
    exp_wr = 1'b0; exp_addr = '0; exp_wdata = '0; exp_rdata = '0; resp_data = '0;
    for (int i = 0; i < ncyc; i++) begin
      checks++;
      if (m_req !== (cyc == mreq_at)) begin
        failures++;
        $display("FAIL rand_mreq cyc=%0d got=%b exp=%b", cyc, m_req, (cyc == mreq_at));
      end
      if ((cyc == mreq_at) || (mreq_at >= 0 && cyc > mreq_at && cyc <= done_at)) begin
        checks++;
        if (m_wr !== exp_wr || m_addr !== exp_addr || m_wdata !== exp_wdata) begin
          failures++;
          $display("FAIL rand_cmd cyc=%0d got wr=%b addr=%h wdata=%h exp wr=%b addr=%h wdata=%h", cyc, m_wr, m_addr, m_wdata, exp_wr, exp_addr, exp_wdata);
        end
      end
      e0 = (cyc == ack_at) && (win == 0);
      e1 = (cyc == ack_at) && (win == 1);
      checks++;
      if (p0_ack !== e0 || p1_ack !== e1 || p0_err !== 1'b0 || p1_err !== 1'b0 ||
          p0_rdata !== (e0 ? exp_rdata : '0) || p1_rdata !== (e1 ? exp_rdata : '0)) begin
        failures++;
        $display("FAIL rand_ack cyc=%0d got ack=%b%b err=%b%b rd0=%h rd1=%h exp ack=%b%b rdata=%h", cyc, p0_ack, p1_ack, p0_err, p1_err, p0_rdata, p1_rdata, e0, e1, exp_rdata);
      end
      if (cyc == ack_at) begin
        pend[win] = 1'b0;
        idle_at = cyc + 1;
        ntx++;
      end
      if (cyc == mreq_at) begin
        done_at = cyc + $urandom_range(1, 4);
        resp_data = 16'($urandom);
      end
      in_wait = (mreq_at >= 0) && (cyc >= mreq_at) && (cyc <= done_at);
      if (cyc == done_at) begin
        m_done = 1'b1;
        m_rdata = resp_data;
        ack_at = cyc + 1;
        exp_rdata = exp_wr ? '0 : resp_data;
      end else begin
        m_rdata = 16'($urandom);
        m_done = !in_wait && ($urandom_range(0, 7) == 0);
      end
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && i < ncyc - 20 && $urandom_range(0, 2) == 0) begin
          pend[p] = 1'b1;
          cw[p] = 1'($urandom_range(0, 1));
          ca[p] = ADDR_W'($urandom);
          cd[p] = DATA_W'($urandom);
        end
      end
      p0_req = pend[0]; p0_wr = cw[0]; p0_addr = ca[0]; p0_wdata = cd[0];
      p1_req = pend[1]; p1_wr = cw[1]; p1_addr = ca[1]; p1_wdata = cd[1];
      if (cyc == idle_at) begin
        if (pend[0] || pend[1]) begin
          win = (pend[1] && (!pend[0] || streak >= MAX_RUN)) ? 1 : 0;
          if (win == 1) streak = 0;
          else if (streak < MAX_RUN) streak++;
          exp_wr = cw[win]; exp_addr = ca[win]; exp_wdata = cd[win];
          mreq_at = cyc + 1;
          idle_at = -1;
        end else begin
          streak = 0;
          idle_at = cyc + 1;
        end
      end
      step();
    end
    m_done = 1'b0;
    checks++;
    if (ntx < 20) begin
      failures++;
      $display("FAIL rand_tx_count got=%0d exp>=20", ntx);
    end
    $display("test_random done transactions=%0d", ntx);
  endtask

  initial begin
    reset = 1'b1;
    p0_req = 1'b0; p0_wr = 1'b0; p0_addr = '0; p0_wdata = '0;
    p1_req = 1'b0; p1_wr = 1'b0; p1_addr = '0; p1_wdata = '0;
    m_done = 1'b0; m_rdata = '0;
    test_reset();
    test_p0_read();
    test_p1_write();
    test_fairness();
    test_timeout();
    test_timeout_edge();
    test_reset_in_wait();
    test_random(800);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
